// File: rtl/mul_4bit_pkg.sv
// rtl/mul_4bit_pkg.sv - shared widths and types for the 4x4 multiplier
package mul_4bit_pkg;

    localparam int A_W = 4;
    localparam int B_W = 4;
    localparam int P_W = A_W + B_W;

    typedef logic [A_W-1:0] operand_t;
    typedef logic [P_W-1:0] product_t;

endpackage

// File: rtl/mul_4bit_fa.sv
// rtl/mul_4bit_fa.sv - one-bit full adder cell for the multiplier array
module mul_4bit_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/mul_4bit.sv
// rtl/mul_4bit.sv - unsigned 4x4 carry-save array multiplier with registered product
module mul_4bit
    import mul_4bit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p,
    output logic           out_valid
);

    // pp[i][j] carries weight i+j
    logic pp [0:3][0:3];

    for (genvar i = 0; i < 4; i++) begin : g_pp_row
        for (genvar j = 0; j < 4; j++) begin : g_pp_col
            assign pp[i][j] = a[j] & b[i];
        end
    end

    // Row r, cell j: sum has weight r+j, carry has weight r+j+1
    logic s_w [1:3][0:3];
    logic c_w [1:3][0:3];

    for (genvar r = 1; r < 4; r++) begin : g_csa_row
        for (genvar j = 0; j < 4; j++) begin : g_csa_col
            logic y_w;
            logic ci_w;

            if (r == 1) begin : g_first
                if (j < 3) begin : g_in
                    assign y_w = pp[0][j+1];
                end else begin : g_edge
                    assign y_w = 1'b0;
                end
                assign ci_w = 1'b0;
            end else begin : g_inner
                if (j < 3) begin : g_in
                    assign y_w = s_w[r-1][j+1];
                end else begin : g_edge
                    assign y_w = 1'b0;
                end
                assign ci_w = c_w[r-1][j];
            end

            mul_4bit_fa u_fa (
                .a    (pp[r][j]),
                .b    (y_w),
                .cin  (ci_w),
                .s    (s_w[r][j]),
                .cout (c_w[r][j])
            );
        end
    end

    // Final ripple row merges the leftover sums and carries into p[6:4]
    logic rs_w [0:2];
    logic rc_w [0:2];

    for (genvar k = 0; k < 3; k++) begin : g_ripple
        logic ci_w;
        if (k == 0) begin : g_lsb
            assign ci_w = 1'b0;
        end else begin : g_chain
            assign ci_w = rc_w[k-1];
        end

        mul_4bit_fa u_fa (
            .a    (c_w[3][k]),
            .b    (s_w[3][k+1]),
            .cin  (ci_w),
            .s    (rs_w[k]),
            .cout (rc_w[k])
        );
    end

    product_t prod_w;

    assign prod_w[0] = pp[0][0];
    assign prod_w[1] = s_w[1][0];
    assign prod_w[2] = s_w[2][0];
    assign prod_w[3] = s_w[3][0];
    assign prod_w[4] = rs_w[0];
    assign prod_w[5] = rs_w[1];
    assign prod_w[6] = rs_w[2];
    // 15*15 fits in 8 bits, so these two can never both be set and no carry leaves bit 7
    assign prod_w[7] = c_w[3][3] ^ rc_w[2];

    product_t p_q;
    product_t p_d;
    logic     out_valid_q;
    logic     out_valid_d;

    // Selecting p_q when idle keeps unknown operands from reaching the register
    always_comb begin
        p_d         = p_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            p_d         = prod_w;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_4bit.sv
// tb/tb_mul_4bit.sv - directed and exhaustive self-checking bench for mul_4bit
module tb_mul_4bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       out_valid;

    int checks;
    int failures;

    mul_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd0;

        step(1'b1, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        chk("reset_p", {24'd0, p}, 32'h00);
        chk("reset_ov", {31'd0, out_valid}, 32'd0);

        step(1'b0, 1'b1, 4'd5, 4'd6);
        chk("basic_p", {24'd0, p}, 32'h1E);
        chk("basic_ov", {31'd0, out_valid}, 32'd1);

        step(1'b0, 1'b1, 4'd3, 4'd0);
        chk("seq0_p", {24'd0, p}, 32'h00);
        chk("seq0_ov", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b1, 4'd12, 4'd14);
        chk("seq1_p", {24'd0, p}, 32'hA8);
        chk("seq1_ov", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b1, 4'd11, 4'd9);
        chk("seq2_p", {24'd0, p}, 32'h63);
        chk("seq2_ov", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b1, 4'd9, 4'd9);
        chk("seq3_p", {24'd0, p}, 32'h51);
        chk("seq3_ov", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b1, 4'd0, 4'd0);
        chk("seq4_p", {24'd0, p}, 32'h00);
        chk("seq4_ov", {31'd0, out_valid}, 32'd1);

        step(1'b0, 1'b1, 4'd15, 4'd15);
        chk("max_p", {24'd0, p}, 32'hE1);
        chk("max_ov", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b0, 4'd1, 4'd1);
        chk("hold_p", {24'd0, p}, 32'hE1);
        chk("hold_ov", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
        chk("xhold_p", {24'd0, p}, 32'hE1);
        chk("xhold_ov", {31'd0, out_valid}, 32'd0);

        step(1'b1, 1'b1, 4'd12, 4'd14);
        chk("rstpri_p", {24'd0, p}, 32'h00);
        chk("rstpri_ov", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 4'd12, 4'd14);
        chk("afterrst_p", {24'd0, p}, 32'hA8);
        chk("afterrst_ov", {31'd0, out_valid}, 32'd1);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                step(1'b0, 1'b1, 4'(ia), 4'(ib));
                chk($sformatf("exh_p_%0d_%0d", ia, ib), {24'd0, p}, 32'(ia * ib));
                chk($sformatf("exh_ov_%0d_%0d", ia, ib), {31'd0, out_valid}, 32'd1);
            end
        end

        step(1'b0, 1'b0, 4'd0, 4'd0);
        chk("idle_ov", {31'd0, out_valid}, 32'd0);
        chk("idle_p", {24'd0, p}, 32'hE1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
